// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the CPU in reset until loaded.
// Optional trailing XOR checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_BUS_WIDTH = 16,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      mem_we,
    output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      cpu_rst_n
);

    // Largest legal payload length, evaluated at 33 bits so a full-memory image still fits.
    localparam logic [32:0] LEN_LIMIT = (33'd1 << ADDR_BUS_WIDTH) - 33'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
`endif

    state_t                    state_q, state_d;
    logic [1:0]                hdr_cnt_q, hdr_cnt_d;
    logic [31:0]               len_q, len_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
    logic                      s_ready_q, s_ready_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDR_BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]                mem_wdata_q, mem_wdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      cpu_rst_n_q, cpu_rst_n_d;
    logic                      xfer;
    logic [31:0]               hdr_len;
    state_t                    end_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    assign xfer    = s_valid && s_ready_q;
    assign hdr_len = {len_q[23:0], s_data};

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign end_state = CSUM;
`else
    assign end_state = DONE;
`endif

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = HDR;
                    hdr_cnt_d = '0;
                    len_d     = '0;
                    addr_d    = ADDR_BUS_WIDTH'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    len_d     = hdr_len;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ s_data;
`endif
                    if (hdr_cnt_q == 2'd3) begin
                        if ({1'b0, hdr_len} > LEN_LIMIT) state_d = ERR;
                        else if (hdr_len == '0)         state_d = end_state;
                        else                            state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = s_data;
                    addr_d      = addr_q + 1'b1;
                    len_d       = len_q - 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ s_data;
`endif
                    if (len_q == 32'd1) state_d = end_state;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) state_d = (s_data == csum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they align with it.
        s_ready_d   = (state_d == HDR) || (state_d == DATA) || (state_d == end_state && state_d != DONE);
        busy_d      = s_ready_d;
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
        cpu_rst_n_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule
